// File: rtl/hilo_div_ctrl_if.sv
// Signal bundle between control, the iterative divider and the HI/LO sequencer.
// The slave modport is the sequencer's view; master is everything around it.
interface hilo_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             div_req;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wr_data;
    logic             div_done;
    logic             div_zero;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic             div_ctrl;
    logic             div_clr;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero_exc;
    logic             timeout_err;

    modport slave (
        input  div_req, mthi, mtlo, wr_data,
        input  div_done, div_zero, div_hi, div_lo,
        output div_ctrl, div_clr, busy, hi, lo, div_zero_exc, timeout_err
    );

    modport master (
        output div_req, mthi, mtlo, wr_data,
        output div_done, div_zero, div_hi, div_lo,
        input  div_ctrl, div_clr, busy, hi, lo, div_zero_exc, timeout_err
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequences the iterative divider: clear, run with watchdog, capture into HI/LO.
// Also owns the architectural HI/LO registers for mfhi/mflo/mthi/mtlo.
module hilo_div_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 48,
    parameter int CW      = 6
) (
    input  logic           clk,
    input  logic           reset,
    hilo_div_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLR  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    runCnt_q, runCnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             divCtrl_q, divCtrl_d;
    logic             divClr_q, divClr_d;
    logic             busy_q, busy_d;
    logic             zeroExc_q, zeroExc_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        runCnt_d  = runCnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divCtrl_d = divCtrl_q;
        divClr_d  = 1'b0;
        zeroExc_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                divCtrl_d = 1'b0;
                if (bus.mthi) hi_d = bus.wr_data;
                if (bus.mtlo) lo_d = bus.wr_data;
                if (bus.div_req) begin
                    state_d  = CLR;
                    divClr_d = 1'b1;
                end
            end
            CLR: begin
                state_d   = RUN;
                runCnt_d  = '0;
                divCtrl_d = 1'b1;
            end
            RUN: begin
                divCtrl_d = 1'b1;
                runCnt_d  = runCnt_q + CW'(1);
                // The divider only registers divZero during its first enabled cycle.
                if (runCnt_q != '0) begin
                    if (bus.div_zero) begin
                        zeroExc_d = 1'b1;
                        divCtrl_d = 1'b0;
                        runCnt_d  = '0;
                        state_d   = IDLE;
                    end else if (bus.div_done) begin
                        hi_d      = bus.div_hi;
                        lo_d      = bus.div_lo;
                        divCtrl_d = 1'b0;
                        runCnt_d  = '0;
                        state_d   = DONE;
                    end else if (runCnt_q == CW'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        divCtrl_d = 1'b0;
                        runCnt_d  = '0;
                        state_d   = IDLE;
                    end
                end
            end
            DONE: begin
                divCtrl_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                divCtrl_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            runCnt_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divCtrl_q <= 1'b0;
            divClr_q  <= 1'b0;
            busy_q    <= 1'b0;
            zeroExc_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            runCnt_q  <= runCnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divCtrl_q <= divCtrl_d;
            divClr_q  <= divClr_d;
            busy_q    <= busy_d;
            zeroExc_q <= zeroExc_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.div_ctrl     = divCtrl_q;
    assign bus.div_clr      = divClr_q;
    assign bus.busy         = busy_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.div_zero_exc = zeroExc_q;
    assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: behavioural divider model plus an expected-result queue
// filled at request time and drained when the sequencer returns to idle.
module tb_hilo_div_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hilo_div_ctrl_if #(.WIDTH(32)) bus ();

    hilo_div_ctrl #(.WIDTH(32), .TIMEOUT(48), .CW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Divider model: cleared by div_clr, samples divZero on its first enabled edge,
    // and raises divOut after 33 enabled cycles unless stubbed out.
    logic [31:0] dividend;
    logic [31:0] divisor;
    bit          stubMode;
    int          divCnt;
    logic        zeroReg;

    always @(posedge clk) begin
        if (reset || bus.div_clr) begin
            divCnt  <= 0;
            zeroReg <= 1'b0;
        end else if (bus.div_ctrl) begin
            if (divCnt == 0) zeroReg <= (divisor == 32'd0);
            divCnt <= divCnt + 1;
        end
    end

    assign bus.div_zero = zeroReg;
    assign bus.div_done = !stubMode && !zeroReg && (divCnt >= 33);
    assign bus.div_lo   = (divisor == 32'd0) ? 32'd0 : 32'($signed(dividend) / $signed(divisor));
    assign bus.div_hi   = (divisor == 32'd0) ? 32'd0 : 32'($signed(dividend) % $signed(divisor));

    typedef struct {
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sbQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".hi"}, bus.hi, 32'd0);
        checkOutput({tag, ".lo"}, bus.lo, 32'd0);
        checkOutput({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, ".divCtrl"}, {31'd0, bus.div_ctrl}, 32'd0);
        checkOutput({tag, ".divClr"}, {31'd0, bus.div_clr}, 32'd0);
        checkOutput({tag, ".zeroExc"}, {31'd0, bus.div_zero_exc}, 32'd0);
        checkOutput({tag, ".timeout"}, {31'd0, bus.timeout_err}, 32'd0);
    endtask

    task automatic writeHiLo(input bit doHi, input bit doLo, input logic [31:0] data);
        bus.mthi    = doHi;
        bus.mtlo    = doLo;
        bus.wr_data = data;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
    endtask

    // kind: 0 capture, 1 divide-by-zero, 2 watchdog, 3 aborted by reset.
    // Cycle n counts samples after the request edge; n=2 is the first RUN cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit stub,
                                 input int kind, input logic [31:0] expHi, input logic [31:0] expLo,
                                 input int pokeAt, input int resetAt);
        exp_t        e;
        int          fallAt, excCnt, toutCnt, clrCnt, pulseAt, expFall;
        logic [31:0] hiBefore, loBefore;
        dividend = a;
        divisor  = b;
        stubMode = stub;
        e.kind = kind;
        e.hi   = expHi;
        e.lo   = expLo;
        sbQ.push_back(e);
        hiBefore = bus.hi;
        loBefore = bus.lo;
        bus.div_req = 1'b1;
        tick();
        bus.div_req = 1'b0;
        checkOutput("busyRise", {31'd0, bus.busy}, 32'd1);
        checkOutput("clrPulse", {31'd0, bus.div_clr}, 32'd1);
        checkOutput("ctrlInClr", {31'd0, bus.div_ctrl}, 32'd0);
        clrCnt  = 1;
        excCnt  = 0;
        toutCnt = 0;
        fallAt  = -1;
        pulseAt = -1;
        for (int n = 2; n <= 100 && fallAt < 0; n++) begin
            tick();
            bus.div_req = 1'b0;
            bus.mthi    = 1'b0;
            bus.mtlo    = 1'b0;
            if (bus.div_clr) clrCnt++;
            if (bus.div_zero_exc) begin excCnt++; pulseAt = n; end
            if (bus.timeout_err) begin toutCnt++; pulseAt = n; end
            if (n == 3 && kind == 0) checkOutput("ctrlInRun", {31'd0, bus.div_ctrl}, 32'd1);
            if (n == 35 && kind == 0) checkOutput("hiOldAtCapture", bus.hi, hiBefore);
            if (pokeAt > 0 && n == pokeAt + 1) begin
                checkOutput("busyWriteHi", bus.hi, hiBefore);
                checkOutput("busyWriteLo", bus.lo, loBefore);
            end
            if (resetAt > 0 && n == resetAt) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                checkAllZero("midRunReset");
                fallAt = n + 1;
            end else if (!bus.busy) begin
                fallAt = n;
            end
            if (pokeAt > 0 && n == pokeAt) begin
                bus.mthi    = 1'b1;
                bus.mtlo    = 1'b1;
                bus.wr_data = 32'h1234;
                bus.div_req = 1'b1;
            end
        end
        e = sbQ.pop_front();
        case (e.kind)
            0:       expFall = 37;
            1:       expFall = 4;
            2:       expFall = 50;
            default: expFall = resetAt + 1;
        endcase
        checkOutput("fallCycle", fallAt, expFall);
        checkOutput("excCount", excCnt, (e.kind == 1) ? 32'd1 : 32'd0);
        checkOutput("toutCount", toutCnt, (e.kind == 2) ? 32'd1 : 32'd0);
        checkOutput("clrCount", clrCnt, 32'd1);
        if (e.kind == 1) checkOutput("excCycle", pulseAt, 32'd4);
        if (e.kind == 2) checkOutput("toutCycle", pulseAt, 32'd50);
        checkOutput("hi", bus.hi, e.hi);
        checkOutput("lo", bus.lo, e.lo);
        checkOutput("ctrlIdle", {31'd0, bus.div_ctrl}, 32'd0);
        if (pokeAt > 0) begin
            tick();
            checkOutput("reqNotQueued", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.div_req = 1'b0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wr_data = 32'd0;
        dividend    = 32'd0;
        divisor     = 32'd1;
        stubMode    = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        applyStimulus(32'd100, 32'd7, 1'b0, 0, 32'd2, 32'd14, 0, 0);
        applyStimulus(-32'sd100, 32'd7, 1'b0, 0, 32'hFFFFFFFE, 32'hFFFFFFF2, 0, 0);
        applyStimulus(32'd9, 32'd3, 1'b0, 0, 32'd0, 32'd3, 0, 0);

        writeHiLo(1'b1, 1'b0, 32'hAAAA);
        writeHiLo(1'b0, 1'b1, 32'h5555);
        checkOutput("preloadHi", bus.hi, 32'hAAAA);
        checkOutput("preloadLo", bus.lo, 32'h5555);
        applyStimulus(32'd5, 32'd0, 1'b0, 1, 32'hAAAA, 32'h5555, 0, 0);

        applyStimulus(32'd5, 32'd1, 1'b1, 2, 32'hAAAA, 32'h5555, 0, 0);

        applyStimulus(32'd100, 32'd7, 1'b0, 0, 32'd2, 32'd14, 10, 0);
        writeHiLo(1'b1, 1'b1, 32'h1234);
        checkOutput("idleWriteHi", bus.hi, 32'h1234);
        checkOutput("idleWriteLo", bus.lo, 32'h1234);

        applyStimulus(32'd100, 32'd7, 1'b0, 3, 32'd0, 32'd0, 0, 12);
        applyStimulus(-32'sd100, 32'd7, 1'b0, 0, 32'hFFFFFFFE, 32'hFFFFFFF2, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
